// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 8-bit simple processor: fetches an instruction
// over a req/ack handshake, then sequences DECODE/EXEC/WB and drives datapath selects.
module control_fsm #(
    parameter int unsigned RETIRE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                imem_ack,
    input  logic [7:0]          instr,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic [7:0]          ir,
    output logic                pc_write,
    output logic                jump,
    output logic                immediate,
    output logic                destination,
    output logic                alu_op,
    output logic                reg_write,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [1:0] CLS_I = 2'b01;
    localparam logic [1:0] CLS_J = 2'b10;
    localparam logic [1:0] CLS_H = 2'b11;

    state_e              state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic                zero_q, zero_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic imem_req_q, imem_req_d;
    logic pc_write_q, pc_write_d;
    logic jump_q, jump_d;
    logic immediate_q, immediate_d;
    logic destination_q, destination_d;
    logic alu_op_q, alu_op_d;
    logic reg_write_q, reg_write_d;
    logic halted_q, halted_d;

    logic is_ri_d;
    logic is_i_d;

    // Next state plus output decode of that next state, so outputs are registered Moore.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        zero_d        = zero_q;
        retired_d     = retired_q;
        imem_req_d    = 1'b0;
        pc_write_d    = 1'b0;
        jump_d        = 1'b0;
        immediate_d   = 1'b0;
        destination_d = 1'b0;
        alu_op_d      = 1'b0;
        reg_write_d   = 1'b0;
        halted_d      = 1'b0;

        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = (ir_q[7:6] == CLS_H) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + RETIRE_W'(1);
                if (!ir_q[7]) begin
                    zero_d = alu_zero;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        is_ri_d = !ir_d[7];
        is_i_d  = (ir_d[7:6] == CLS_I);

        imem_req_d = (state_d == S_FETCH);
        halted_d   = (state_d == S_HALT);

        if ((state_d == S_EXEC || state_d == S_WB) && is_ri_d) begin
            alu_op_d      = is_i_d ? ir_d[0] : ir_d[5];
            immediate_d   = is_i_d;
            destination_d = is_i_d;
        end

        // Conditional jumps see the flag from the last R/I writeback.
        if (state_d == S_WB) begin
            pc_write_d  = 1'b1;
            reg_write_d = is_ri_d;
            jump_d      = (ir_d[7:6] == CLS_J) && (!ir_d[5] || zero_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ir_q          <= 8'h00;
            zero_q        <= 1'b0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            pc_write_q    <= 1'b0;
            jump_q        <= 1'b0;
            immediate_q   <= 1'b0;
            destination_q <= 1'b0;
            alu_op_q      <= 1'b0;
            reg_write_q   <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            zero_q        <= zero_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            pc_write_q    <= pc_write_d;
            jump_q        <= jump_d;
            immediate_q   <= immediate_d;
            destination_q <= destination_d;
            alu_op_q      <= alu_op_d;
            reg_write_q   <= reg_write_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign ir          = ir_q;
    assign pc_write    = pc_write_q;
    assign jump        = jump_q;
    assign immediate   = immediate_q;
    assign destination = destination_q;
    assign alu_op      = alu_op_q;
    assign reg_write   = reg_write_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks instructions through the handshake and
// checks the output bundle, ir and retired count at every state.
module tb_control_fsm;

    localparam int unsigned RETIRE_W = 8;
    // Output bundle bit order: {imem_req, pc_write, jump, immediate, destination, alu_op, reg_write, halted}
    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_REQ  = 8'h80;
    localparam logic [7:0] O_HALT = 8'h01;

    logic                clk;
    logic                reset;
    logic                imem_ack;
    logic [7:0]          instr;
    logic                alu_zero;
    logic                imem_req;
    logic [7:0]          ir;
    logic                pc_write;
    logic                jump;
    logic                immediate;
    logic                destination;
    logic                alu_op;
    logic                reg_write;
    logic                halted;
    logic [RETIRE_W-1:0] retired;
    logic [7:0]          outs;

    int n_asserts = 0;
    int n_fails   = 0;

    control_fsm #(.RETIRE_W(RETIRE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .imem_req   (imem_req),
        .ir         (ir),
        .pc_write   (pc_write),
        .jump       (jump),
        .immediate  (immediate),
        .destination(destination),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .halted     (halted),
        .retired    (retired)
    );

    assign outs = {imem_req, pc_write, jump, immediate, destination, alu_op, reg_write, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge while in FETCH; leaves at the negedge of the next FETCH.
    task automatic run_instr(input logic [7:0] ins, input logic az, input int waits,
                             input logic [7:0] exp_exec, input logic [7:0] exp_wb,
                             input logic [7:0] exp_ret);
        imem_ack = 1'b0;
        instr    = ~ins;
        for (int i = 0; i < waits; i++) begin
            tick();
            check("fetch_wait", 32'(outs), 32'(O_REQ));
        end
        imem_ack = 1'b1;
        instr    = ins;
        tick();
        check("decode_outs", 32'(outs), 32'(O_NONE));
        check("decode_ir", 32'(ir), 32'(ins));
        // Acks outside FETCH must not disturb ir.
        instr = ~ins;
        tick();
        check("exec_outs", 32'(outs), 32'(exp_exec));
        alu_zero = az;
        tick();
        check("wb_outs", 32'(outs), 32'(exp_wb));
        check("wb_ir", 32'(ir), 32'(ins));
        imem_ack = 1'b0;
        tick();
        check("next_fetch", 32'(outs), 32'(O_REQ));
        check("retired", 32'(retired), 32'(exp_ret));
        alu_zero = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        imem_ack = 1'b0;
        instr    = 8'h00;
        alu_zero = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'(outs), 32'(O_NONE));
        check("reset_ir", 32'(ir), 32'h0);
        check("reset_retired", 32'(retired), 32'h0);

        reset = 1'b0;
        tick();
        check("first_req", 32'(outs), 32'(O_REQ));

        run_instr(8'h25, 1'b0, 0, 8'h04, 8'h46, 8'd1);
        run_instr(8'h7A, 1'b0, 0, 8'h18, 8'h5A, 8'd2);
        run_instr(8'h25, 1'b1, 0, 8'h04, 8'h46, 8'd3);
        run_instr(8'hA3, 1'b0, 0, 8'h00, 8'h60, 8'd4);
        run_instr(8'h05, 1'b0, 0, 8'h00, 8'h42, 8'd5);
        run_instr(8'hA3, 1'b1, 0, 8'h00, 8'h40, 8'd6);
        run_instr(8'hA3, 1'b0, 0, 8'h00, 8'h40, 8'd7);
        run_instr(8'h85, 1'b0, 0, 8'h00, 8'h60, 8'd8);
        run_instr(8'h7A, 1'b1, 3, 8'h18, 8'h5A, 8'd9);

        imem_ack = 1'b1;
        instr    = 8'hC0;
        tick();
        check("halt_decode", 32'(outs), 32'(O_NONE));
        check("halt_ir", 32'(ir), 32'hC0);
        instr = 8'h25;
        tick();
        check("halted", 32'(outs), 32'(O_HALT));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_stays", 32'(outs), 32'(O_HALT));
        end
        check("halt_retired", 32'(retired), 32'd9);
        check("halt_ir_hold", 32'(ir), 32'hC0);

        imem_ack = 1'b0;
        reset    = 1'b1;
        tick();
        check("halt_reset_outs", 32'(outs), 32'(O_NONE));
        check("halt_reset_ir", 32'(ir), 32'h0);
        check("halt_reset_ret", 32'(retired), 32'h0);
        reset = 1'b0;
        tick();
        check("restart_req", 32'(outs), 32'(O_REQ));

        for (int i = 1; i <= 256; i++) begin
            run_instr(8'h25, 1'b0, 0, 8'h04, 8'h46, 8'(i));
        end
        check("wrap_retired", 32'(retired), 32'h0);

        // Reset during FETCH with a coincident ack: ack is dropped.
        imem_ack = 1'b1;
        instr    = 8'h7A;
        reset    = 1'b1;
        tick();
        check("fetch_reset_outs", 32'(outs), 32'(O_NONE));
        check("fetch_reset_ir", 32'(ir), 32'h0);
        check("fetch_reset_ret", 32'(retired), 32'h0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        tick();
        check("post_reset_req", 32'(outs), 32'(O_REQ));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 8-bit simple processor. It fetches one instruction per pass through a request/acknowledge handshake with instruction memory and holds it in an internal instruction register. It then drives the select and enable lines consumed by the datapath: ProgramCounter write, JumpMux, ImmMux, DestMux, ALU op and register-file write. It sits directly upstream of the ProgramCounter and the three muxes.

## Interface
- RETIRE_W, 8: width of the retired-instruction counter.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_ack  in  1  instruction memory acknowledge; `instr` is valid in the same cycle.
- instr  in  8  instruction word from memory.
- alu_zero  in  1  ALU result-is-zero, valid during WB.
- imem_req  out  1  fetch request.
- ir  out  8  current instruction register.
- pc_write  out  1  ProgramCounter load enable.
- jump  out  1  JumpMux select: 1 = branch target, 0 = PC+1 from Addr.
- immediate  out  1  ImmMux select: 1 = sign-extended imm3.
- destination  out  1  DestMux select: 1 = rd from ir[2:1], 0 = rd from ir[4:3].
- alu_op  out  1  ALU operation bit.
- reg_write  out  1  register-file write enable.
- halted  out  1  processor stopped.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
Instruction classes, decoded from ir[7:6]:
- 00 R-type: alu_op = ir[5], rd = ir[4:3], rs = ir[2:1].
- 01 I-type: imm3 = ir[5:3], rd = ir[2:1], alu_op = ir[0].
- 10 J-type: cond = ir[5], imm5 = ir[4:0]. cond = 0 is an unconditional jump; cond = 1 jumps only if zero_flag = 1.
- 11 HALT: ir[5:0] ignored.

States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE -> FETCH unconditionally.
- FETCH: imem_req = 1.
  - On imem_ack = 1: ir <= instr, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE -> HALT if class is 11; otherwise -> EXEC.
- EXEC -> WB.
- WB -> FETCH.
- HALT: stays in HALT until reset.

Outputs are Moore, decoded from state and ir. Every output not listed below is 0.
- EXEC and WB, R/I-type: alu_op valid. immediate = 1 for I-type. destination = 1 for I-type, 0 for R-type.
- WB, R/I-type:
  - reg_write = 1 and pc_write = 1, jump = 0.
  - zero_flag <= alu_zero.
- WB, J-type: pc_write = 1, jump = taken.
- WB, any class: retired increments by 1. It wraps from 2^RETIRE_W − 1 to 0.
- HALT: halted = 1.

Rules:
- zero_flag is internal and changes only in WB of R/I-type instructions. J-type instructions neither read nor update it in WB except for the taken decision.
- imem_ack is ignored outside FETCH.
- `instr` is sampled only on the edge where FETCH and imem_ack are both 1.

## Timing
- Reset, synchronous: on a clock edge with reset = 1, the block sets state = IDLE, ir = 0, zero_flag = 0, retired = 0.
  - All outputs read 0 in IDLE.
  - Reset takes priority in every state, including mid-handshake and HALT.
  - An ack that coincides with reset is dropped.
- imem_req rises one cycle after reset deasserts, because the block passes through IDLE for one cycle.
- Latency per instruction is 3 + N cycles: FETCH for N ≥ 1 cycles, then DECODE, EXEC, WB at 1 cycle each. With zero-wait ack an instruction takes 4 cycles.
- pc_write and reg_write are single-cycle pulses in WB. The datapath captures them at the end of WB.
- imem_req stays high continuously until ack. It drops in the cycle after the ack edge.
- The conditional-jump decision uses the zero_flag value registered at the previous R/I WB.
- HALT is entered one cycle after DECODE. No WB occurs for HALT, so retired does not count it.

## Test plan
- Reset then ack held at 1 with instr = 0x25 (R-type, alu_op = 1, rd = 0, rs = 2):
  - imem_req goes high in cycle 1 after reset.
  - The WB cycle shows reg_write = 1, pc_write = 1, jump = 0, destination = 0, alu_op = 1.
  - retired = 1.
- I-type 0x7A (imm3 = 111, rd = 01, alu_op = 0): immediate = 1 and destination = 1 in EXEC and WB.
- Conditional jump 0xA3:
  - Preceded by an R-type with alu_zero = 1 in WB: jump = 1 in WB.
  - Repeat after an R-type with alu_zero = 0: jump = 0, pc_write still 1.
- Ack delayed 3 cycles:
  - imem_req stays high for 4 cycles.
  - An ack pulse injected during EXEC is ignored: ir is unchanged.
- instr = 0xC0:
  - halted = 1 two cycles after the ack edge, and imem_req stays 0 thereafter.
  - Asserting reset for one cycle returns all outputs to 0 and restarts fetch.
- Run 256 single-cycle-ack R-type instructions: retired wraps to 0. Assert reset during FETCH: retired = 0 and ir = 0 after the edge.
